// File: rtl/score_argmax_seq_if.sv
// Stream-in / result-out bundle for the score argmax classifier.
// The slave side is the classifier. The master side is whoever feeds scores and consumes results.
interface score_argmax_seq_if #(
  parameter int BITWIDTH    = 8,
  parameter int NUM_CLASSES = 10
);
  localparam int IDXW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [BITWIDTH-1:0]    in_data;
  logic                   in_last;
  logic                   result_valid;
  logic                   result_ready;
  logic [IDXW-1:0]        class_idx;
  logic [BITWIDTH-1:0]    max_score;
  logic [NUM_CLASSES-1:0] led;
  logic                   frame_err;

  modport master (
    output in_valid, in_data, in_last, result_ready,
    input  in_ready, result_valid, class_idx, max_score, led, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, result_ready,
    output in_ready, result_valid, class_idx, max_score, led, frame_err
  );
endinterface

// File: rtl/score_argmax_seq.sv
// Streams one frame of signed class scores and reports the ReLU-clamped argmax.
// The lowest index wins on ties. Malformed frames are dropped with a one-cycle frame_err pulse.
module score_argmax_seq #(
  parameter int BITWIDTH    = 8,
  parameter int NUM_CLASSES = 10
) (
  input logic               clk,
  input logic               rst,
  score_argmax_seq_if.slave bus
);

  localparam int IDXW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        cnt_q, cnt_d;
  logic [BITWIDTH-1:0]    runMax_q, runMax_d;
  logic [IDXW-1:0]        runIdx_q, runIdx_d;
  logic [IDXW-1:0]        classIdx_q, classIdx_d;
  logic [BITWIDTH-1:0]    maxScore_q, maxScore_d;
  logic [NUM_CLASSES-1:0] led_q, led_d;
  logic                   frameErr_q, frameErr_d;

  logic                   accept;
  logic                   isFinal;
  logic [IDXW-1:0]        beatIdx;
  logic [BITWIDTH-1:0]    clamped;
  logic [BITWIDTH-1:0]    candMax;
  logic [IDXW-1:0]        candIdx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      runMax_q   <= '0;
      runIdx_q   <= '0;
      classIdx_q <= '0;
      maxScore_q <= '0;
      led_q      <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      runMax_q   <= runMax_d;
      runIdx_q   <= runIdx_d;
      classIdx_q <= classIdx_d;
      maxScore_q <= maxScore_d;
      led_q      <= led_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    runMax_d   = runMax_q;
    runIdx_d   = runIdx_q;
    classIdx_d = classIdx_q;
    maxScore_d = maxScore_q;
    led_d      = led_q;
    frameErr_d = 1'b0;

    accept  = bus.in_valid && (state_q != OUT);
    clamped = bus.in_data[BITWIDTH-1] ? '0 : bus.in_data;
    beatIdx = (state_q == IDLE) ? '0 : cnt_q;
    isFinal = (beatIdx == LAST_IDX);

    // The first beat of a frame always seeds the running max. Later beats must strictly beat it.
    if ((state_q == IDLE) || (clamped > runMax_q)) begin
      candMax = clamped;
      candIdx = beatIdx;
    end else begin
      candMax = runMax_q;
      candIdx = runIdx_q;
    end

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          // An in_last flag that disagrees with the beat position means the frame is malformed.
          if (bus.in_last != isFinal) begin
            frameErr_d = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
          end else if (isFinal) begin
            state_d    = OUT;
            cnt_d      = '0;
            runMax_d   = candMax;
            runIdx_d   = candIdx;
            classIdx_d = candIdx;
            maxScore_d = candMax;
            led_d      = NUM_CLASSES'(1) << candIdx;
          end else begin
            state_d  = ACCUM;
            cnt_d    = beatIdx + 1'b1;
            runMax_d = candMax;
            runIdx_d = candIdx;
          end
        end
      end
      OUT: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready     = (state_q != OUT);
  assign bus.result_valid = (state_q == OUT);
  assign bus.class_idx    = classIdx_q;
  assign bus.max_score    = maxScore_q;
  assign bus.led          = led_q;
  assign bus.frame_err    = frameErr_q;

endmodule

// File: tb/tb_score_argmax_seq.sv
// Randomised scoreboard bench for score_argmax_seq.
// The stimulus side queues the expected events, and a negedge monitor pops each one and compares it with what the DUT shows.
module tb_score_argmax_seq;

  typedef struct {
    logic       isErr;
    logic [3:0] idx;
    logic [7:0] score;
    logic [9:0] led;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  int   expValidCyc;
  int   stallLeft;
  bit   randReady;
  exp_t expQ [$];

  exp_t monExp;
  exp_t lastExp;
  bit   holding;
  bit   prevConsumed;

  score_argmax_seq_if #(.BITWIDTH(8), .NUM_CLASSES(10)) bus ();

  score_argmax_seq #(.BITWIDTH(8), .NUM_CLASSES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Higher-level reference: clamp every score, take the maximum, then report the first index that holds it.
  function automatic exp_t modelFrame(input logic [7:0] s [10], input int lastAt);
    exp_t r;
    int   best;
    int   clampVal [10];
    r.isErr = (lastAt != 9);
    r.idx   = '0;
    r.score = '0;
    r.led   = '0;
    best    = 0;
    for (int i = 0; i < 10; i++) clampVal[i] = ($signed(s[i]) < 0) ? 0 : int'(s[i]);
    for (int i = 0; i < 10; i++) if (clampVal[i] > best) best = clampVal[i];
    for (int i = 9; i >= 0; i--) if (clampVal[i] == best) r.idx = 4'(i);
    r.score = 8'(best);
    r.led   = 10'(1) << r.idx;
    return r;
  endfunction

  task automatic sendBeat(input logic [7:0] d, input bit last, output bit ok);
    logic acc;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int b = 0; b < 200 && !ok; b++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL beat_accept actual=timeout expected=accepted");
    end
  endtask

  // lastAt = 9 gives a well-formed frame, lastAt < 9 ends it early, and lastAt = 10 omits in_last.
  task automatic applyStimulus(input logic [7:0] s [10], input int lastAt, input int gapPct);
    bit ok;
    int n;
    expQ.push_back(modelFrame(s, lastAt));
    n = (lastAt < 10) ? lastAt + 1 : 10;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gapPct) begin
        @(posedge clk);
        #1;
      end
      sendBeat(s[i], (i == lastAt), ok);
      if (!ok) return;
      if (i == 9 && lastAt == 9) expValidCyc = cyc;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((expQ.size() != 0 || bus.result_valid) && b < 1000) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 1000) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain actual=pending%0d expected=0", expQ.size());
    end
  endtask

  function automatic logic [7:0] genScore();
    case ($urandom_range(3))
      0:       return 8'($urandom);
      1:       return 8'($urandom_range(0, 15));
      2:       return 8'($urandom_range(200, 255));
      default: return 8'($urandom_range(100, 127));
    endcase
  endfunction

  initial begin
    bus.result_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.result_valid && stallLeft > 0) begin
        bus.result_ready = 1'b0;
        stallLeft--;
      end else if (randReady) begin
        bus.result_ready = 1'($urandom_range(1));
      end else begin
        bus.result_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      holding      = 1'b0;
      prevConsumed = 1'b0;
    end else begin
      if (prevConsumed) checkOutput("idle_after_ready", 32'(bus.result_valid), 32'd0);
      prevConsumed = 1'b0;
      if (bus.frame_err) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_err actual=frame_err expected=none");
        end else begin
          monExp = expQ.pop_front();
          checkOutput("err_expected", 32'(monExp.isErr), 32'd1);
          checkOutput("err_led_kept", 32'(bus.led), 32'(lastExp.led));
          checkOutput("err_idx_kept", 32'(bus.class_idx), 32'(lastExp.idx));
          checkOutput("err_score_kept", 32'(bus.max_score), 32'(lastExp.score));
          checkOutput("err_no_valid", 32'(bus.result_valid), 32'd0);
        end
      end
      if (bus.result_valid) begin
        checkOutput("in_ready_in_out", 32'(bus.in_ready), 32'd0);
        if (!holding) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_result actual=valid expected=none");
          end else begin
            monExp = expQ.pop_front();
            checkOutput("result_expected", 32'(monExp.isErr), 32'd0);
            checkOutput("class_idx", 32'(bus.class_idx), 32'(monExp.idx));
            checkOutput("max_score", 32'(bus.max_score), 32'(monExp.score));
            checkOutput("led", 32'(bus.led), 32'(monExp.led));
            checkOutput("latency", 32'(cyc), 32'(expValidCyc));
            lastExp = monExp;
          end
          holding = 1'b1;
        end else begin
          checkOutput("hold_idx", 32'(bus.class_idx), 32'(lastExp.idx));
          checkOutput("hold_score", 32'(bus.max_score), 32'(lastExp.score));
          checkOutput("hold_led", 32'(bus.led), 32'(lastExp.led));
        end
        if (bus.result_ready) begin
          holding      = 1'b0;
          prevConsumed = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [7:0] s [10];
    bit         ok;
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    expValidCyc  = -1;
    stallLeft    = 0;
    randReady    = 1'b0;
    lastExp      = '{isErr: 1'b0, idx: 4'd0, score: 8'd0, led: 10'd0};
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("rst_idx", 32'(bus.class_idx), 32'd0);
    checkOutput("rst_score", 32'(bus.max_score), 32'd0);
    checkOutput("rst_led", 32'(bus.led), 32'd0);
    checkOutput("rst_err", 32'(bus.frame_err), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] directed frame with tie at 12");
    s = '{8'd5, 8'hFD, 8'd12, 8'd7, 8'd0, 8'd12, 8'd1, 8'h80, 8'd9, 8'd11};
    applyStimulus(s, 9, 0);
    drain();

    $display("[TB] all scores negative");
    s = '{default: 8'hFF};
    applyStimulus(s, 9, 0);
    drain();

    $display("[TB] early in_last then a good frame");
    s = '{8'd3, 8'd90, 8'd4, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
    applyStimulus(s, 4, 0);
    applyStimulus(s, 9, 0);
    drain();

    $display("[TB] missing in_last on final beat");
    applyStimulus(s, 10, 0);
    drain();

    $display("[TB] result_ready stalled while next frame pushes");
    stallLeft = 5;
    applyStimulus(s, 9, 0);
    for (int i = 0; i < 10; i++) s[i] = genScore();
    applyStimulus(s, 9, 0);
    drain();

    $display("[TB] reset in the middle of a frame");
    for (int i = 0; i < 7; i++) sendBeat(8'(i + 20), 1'b0, ok);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    lastExp = '{isErr: 1'b0, idx: 4'd0, score: 8'd0, led: 10'd0};
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("midrst_idx", 32'(bus.class_idx), 32'd0);
    checkOutput("midrst_score", 32'(bus.max_score), 32'd0);
    checkOutput("midrst_led", 32'(bus.led), 32'd0);
    checkOutput("midrst_err", 32'(bus.frame_err), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) s[i] = 8'($urandom_range(0, 126));
    s[9] = 8'd127;
    applyStimulus(s, 9, 0);
    drain();

    $display("[TB] same frame with and without gaps");
    for (int i = 0; i < 10; i++) s[i] = genScore();
    applyStimulus(s, 9, 0);
    applyStimulus(s, 9, 40);
    drain();

    $display("[TB] random frames");
    randReady = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int lastAt;
      for (int i = 0; i < 10; i++) s[i] = genScore();
      case ($urandom_range(9))
        0:       lastAt = int'($urandom_range(0, 8));
        1:       lastAt = 10;
        default: lastAt = 9;
      endcase
      applyStimulus(s, lastAt, int'($urandom_range(0, 30)));
    end
    drain();
    randReady = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
